// File: rtl/corrige_hamming.sv
// Hamming(15,11) single-error corrector with a two-stage valid/ready pipeline
// and a saturating count of delivered words that needed a correction.
module corrige_hamming (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        entrada_valida,
  input  logic [14:0] entrada,
  output logic        entrada_pronta,
  output logic        saida_valida,
  input  logic        saida_pronta,
  output logic [10:0] saida,
  output logic [3:0]  sindrome,
  output logic        erro,
  input  logic        limpa_cont,
  output logic [15:0] cont_corrigidos
);

  // Stage 1 holds the raw codeword plus its syndrome.
  logic        s1_valid;
  logic [14:0] s1_word;
  logic [3:0]  s1_synd;

  logic [3:0]  synd_in;
  logic [10:0] flip_mask;
  logic        load1;
  logic        load2;
  logic        xfer_out;

  // Stage 2 may be overwritten when empty or when its word leaves this cycle.
  assign load2          = !saida_valida || saida_pronta;
  assign load1          = !s1_valid || load2;
  assign entrada_pronta = load1;
  assign xfer_out       = saida_valida && saida_pronta;

  // Syndrome of the incoming word: received parity vs recomputed parity.
  always_comb begin
    synd_in[0] = entrada[11] ^ (^{entrada[0], entrada[1], entrada[3], entrada[4],
                                  entrada[6], entrada[8], entrada[10]});
    synd_in[1] = entrada[12] ^ (^{entrada[0], entrada[2], entrada[3], entrada[5],
                                  entrada[6], entrada[9], entrada[10]});
    synd_in[2] = entrada[13] ^ (^{entrada[1], entrada[2], entrada[3], entrada[7],
                                  entrada[8], entrada[9], entrada[10]});
    synd_in[3] = entrada[14] ^ (^entrada[10:4]);
  end

  // Data bit to invert for the syndrome held in stage 1; parity positions
  // (1,2,4,8) and zero leave the data untouched.
  always_comb begin
    flip_mask = '0;
    case (s1_synd)
      4'd3:    flip_mask[0]  = 1'b1;
      4'd5:    flip_mask[1]  = 1'b1;
      4'd6:    flip_mask[2]  = 1'b1;
      4'd7:    flip_mask[3]  = 1'b1;
      4'd9:    flip_mask[4]  = 1'b1;
      4'd10:   flip_mask[5]  = 1'b1;
      4'd11:   flip_mask[6]  = 1'b1;
      4'd12:   flip_mask[7]  = 1'b1;
      4'd13:   flip_mask[8]  = 1'b1;
      4'd14:   flip_mask[9]  = 1'b1;
      4'd15:   flip_mask[10] = 1'b1;
      default: flip_mask     = '0;
    endcase
  end

  // Stage 1: capture codeword and syndrome; data only sampled on a real transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_synd  <= '0;
    end else if (load1) begin
      s1_valid <= entrada_valida;
      if (entrada_valida) begin
        s1_word <= entrada;
        s1_synd <= synd_in;
      end
    end
  end

  // Stage 2: corrected data and status, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_valida <= 1'b0;
      saida        <= '0;
      sindrome     <= '0;
      erro         <= 1'b0;
    end else if (load2) begin
      saida_valida <= s1_valid;
      if (s1_valid) begin
        saida    <= s1_word[10:0] ^ flip_mask;
        sindrome <= s1_synd;
        erro     <= |s1_synd;
      end
    end
  end

  // Saturating count of delivered corrected words; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_corrigidos <= '0;
    end else if (limpa_cont) begin
      cont_corrigidos <= '0;
    end else if (xfer_out && erro && (cont_corrigidos != 16'hFFFF)) begin
      cont_corrigidos <= cont_corrigidos + 16'd1;
    end
  end

endmodule

// File: tb/tb_corrige_hamming.sv
// Scoreboard bench for corrige_hamming: directed vectors, back-pressure,
// reset flush, counter clear/saturation, and randomized traffic.
module tb_corrige_hamming;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        entrada_valida = 1'b0;
  logic [14:0] entrada = '0;
  logic        entrada_pronta;
  logic        saida_valida;
  logic        saida_pronta = 1'b0;
  logic [10:0] saida;
  logic [3:0]  sindrome;
  logic        erro;
  logic        limpa_cont = 1'b0;
  logic [15:0] cont_corrigidos;

  typedef struct {
    logic [10:0] data;
    logic [3:0]  synd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int unsigned pos2bit[16];
  logic [15:0] cnt_exp = '0;
  int          checks = 0;
  int          fails = 0;
  logic        rand_bp = 1'b0;

  corrige_hamming dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .entrada_valida  (entrada_valida),
    .entrada         (entrada),
    .entrada_pronta  (entrada_pronta),
    .saida_valida    (saida_valida),
    .saida_pronta    (saida_pronta),
    .saida           (saida),
    .sindrome        (sindrome),
    .erro            (erro),
    .limpa_cont      (limpa_cont),
    .cont_corrigidos (cont_corrigidos)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Classic Hamming view: syndrome is the XOR of positions of all set bits.
  function automatic int unsigned synd_of(input logic [14:0] cw);
    int unsigned s = 0;
    for (int p = 1; p < 16; p++)
      if (cw[pos2bit[p]]) s ^= p;
    return s;
  endfunction

  function automatic exp_t model(input logic [14:0] cw);
    exp_t        e;
    logic [14:0] c = cw;
    int unsigned s = synd_of(cw);
    if (s != 0) c[pos2bit[s]] = ~c[pos2bit[s]];
    e.data = c[10:0];
    e.synd = 4'(s);
    e.err  = (s != 0);
    return e;
  endfunction

  function automatic logic [14:0] encode(input logic [10:0] d);
    logic [14:0] cw = {4'b0000, d};
    int unsigned s  = synd_of(cw);
    for (int k = 0; k < 4; k++)
      if (s[k]) cw[11 + k] = 1'b1;
    return cw;
  endfunction

  // Expected responses enter the scoreboard at each accepted input.
  always @(negedge clk)
    if (rst_n && entrada_valida && entrada_pronta) sb.push_back(model(entrada));

  // Monitor: compares every delivered word and tracks the counter.
  always @(negedge clk) begin
    exp_t e;
    logic eerr;
    if (rst_n) begin
      check("cont_corrigidos", cont_corrigidos, cnt_exp);
      eerr = 1'b0;
      if (saida_valida && saida_pronta) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got saida=%0h with empty scoreboard, required no transfer", saida);
        end else begin
          e = sb.pop_front();
          eerr = e.err;
          check("saida", saida, e.data);
          check("sindrome", sindrome, e.synd);
          check("erro", erro, e.err);
        end
      end
      if (limpa_cont) cnt_exp = '0;
      else if (eerr && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
    end
  end

  // Random downstream back-pressure during the random phase.
  always @(posedge clk)
    if (rand_bp) begin
      #1;
      saida_pronta = ($urandom_range(0, 3) != 0);
    end

  // Present a word until accepted; called and returns at posedge+1.
  task automatic send(input logic [14:0] cw);
    bit done = 0;
    entrada_valida = 1'b1;
    entrada = cw;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = entrada_pronta;
      @(posedge clk);
      #1;
    end
    entrada_valida = 1'b0;
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: got no acceptance of %0h, required acceptance within 200 cycles", cw);
    end
  endtask

  task automatic drain();
    bit done = 0;
    saida_pronta = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !saida_valida;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned k = 0;
    logic [14:0] cw;
    for (int p = 1; p < 16; p++)
      if ((p & (p - 1)) == 0) pos2bit[p] = 11 + ((p == 1) ? 0 : (p == 2) ? 1 : (p == 4) ? 2 : 3);
      else pos2bit[p] = k++;

    // Reset state
    #12;
    check("rst_saida_valida", saida_valida, 0);
    check("rst_saida", saida, 0);
    check("rst_sindrome", sindrome, 0);
    check("rst_erro", erro, 0);
    check("rst_cont", cont_corrigidos, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_entrada_pronta", entrada_pronta, 1);

    // Latency of a clean zero word: valid after the second edge
    @(posedge clk);
    #1;
    saida_pronta = 1'b1;
    entrada_valida = 1'b1;
    entrada = 15'h0000;
    @(posedge clk);
    #1;
    entrada_valida = 1'b0;
    @(negedge clk);
    check("latency_edge1", saida_valida, 0);
    @(negedge clk);
    check("latency_edge2", saida_valida, 1);
    @(posedge clk);
    #1;

    // Directed vectors
    send(15'h7FF7);
    send(15'h3FFF);
    send(15'h1801);
    drain();
    check("cont_after_directed", cont_corrigidos, 2);

    // Back-pressure: two accepted, third refused, then all delivered in order
    saida_pronta = 1'b0;
    entrada_valida = 1'b1;
    entrada = 15'h0001;
    @(negedge clk);
    check("bp_accept0", entrada_pronta, 1);
    @(posedge clk);
    #1;
    entrada = 15'h7FFF;
    @(negedge clk);
    check("bp_accept1", entrada_pronta, 1);
    @(posedge clk);
    #1;
    entrada = 15'h1801;
    @(negedge clk);
    check("bp_full", entrada_pronta, 0);
    @(posedge clk);
    #1;
    check("bp_still_full", entrada_pronta, 0);
    saida_pronta = 1'b1;
    send(15'h1801);
    drain();
    check("bp_order_count", cont_corrigidos, 3);

    // Reset with two words buffered
    saida_pronta = 1'b0;
    send(15'h7FF7);
    send(15'h3FFF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_saida_valida", saida_valida, 0);
    check("midrst_cont", cont_corrigidos, 0);
    sb.delete();
    cnt_exp = '0;
    saida_pronta = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_no_output", saida_valida, 0);
    end
    @(posedge clk);
    #1;

    // Clear coincident with an erroneous output transfer
    send(15'h7FF7);
    drain();
    check("cont_before_clear", cont_corrigidos, 1);
    saida_pronta = 1'b0;
    send(15'h3FFF);
    @(posedge clk);
    #1;
    check("clear_word_waiting", saida_valida & erro, 1);
    limpa_cont = 1'b1;
    saida_pronta = 1'b1;
    @(posedge clk);
    #1;
    limpa_cont = 1'b0;
    check("clear_overrides_inc", cont_corrigidos, 0);

    // Randomized traffic with random stalls and occasional clears
    rand_bp = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      limpa_cont = ($urandom_range(0, 63) == 0);
      cw = encode(11'($urandom));
      case ($urandom_range(0, 3))
        0: ;
        1, 2: cw[$urandom_range(0, 14)] = ~cw[$urandom_range(0, 14)];
        default: cw = 15'($urandom);
      endcase
      send(cw);
    end
    limpa_cont = 1'b0;
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    drain();

    // Saturation at 16'hFFFF
    limpa_cont = 1'b1;
    @(posedge clk);
    #1;
    limpa_cont = 1'b0;
    saida_pronta = 1'b1;
    for (int n = 0; n < 65540; n++) send(15'h7FF7);
    drain();
    check("cont_saturated", cont_corrigidos, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
